// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and constants for the bit-serial MAC controller.
//   seq_acc_cfg_t           - run-time job configuration (latched per job)
//   seq_acc_state_t         - controller FSM states
//   SEQ_ACC_MAX_ADC_LATENCY - largest supported mac_en -> adc sample delay
package qracc_pkg;

    localparam int SEQ_ACC_MAX_ADC_LATENCY = 4;

    // clog2(16)+1 bits so that a tile count equal to maxTiles is representable.
    localparam int SEQ_ACC_TILES_CFG_W = 5;

    typedef struct packed {
        logic [3:0]                     n_input_bits;
        logic                           unsigned_acts;
        logic [SEQ_ACC_TILES_CFG_W-1:0] n_tiles;
        logic [3:0]                     adc_ref_range_shifts;
    } seq_acc_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERIAL = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUT    = 2'd3
    } seq_acc_state_t;

endpackage

// File: rtl/bit_plane_piso.sv
// bit_plane_piso: per-lane parallel-in/serial-out register that presents one
// activation bit-plane per shift, LSB first.
//   clk, nrst : clock, synchronous active-low reset (clears the register)
//   load_i    : capture data_i (takes priority over shift_i)
//   shift_i   : shift every lane right by one bit
//   data_i    : lanes x depth activations, lane l at [l*depth +: depth]
//   bits_o    : bit 0 of every lane
module bit_plane_piso #(
    parameter int lanes = 128,
    parameter int depth = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [lanes*depth-1:0] data_i,
    output logic [lanes-1:0]       bits_o
);

    logic [lanes*depth-1:0] shreg_q;
    logic [lanes*depth-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            // Shift each lane independently so no bit leaks across lane boundaries.
            for (int l = 0; l < lanes; l++) begin
                shreg_d[l*depth +: depth] = shreg_q[l*depth +: depth] >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        bits_o = '0;
        for (int l = 0; l < lanes; l++) begin
            bits_o[l] = shreg_q[l*depth];
        end
    end

endmodule

// File: rtl/seq_acc_tiled.sv
// seq_acc_tiled: bit-serial MAC controller. Streams activation bit-planes into
// the charge-domain array, weights the returned ADC codes by bit position and
// accumulates them into signed partial sums over a run-time number of tiles.
//   clk, nrst               : clock, synchronous active-low reset
//   cfg                     : job configuration, latched on the first-tile handshake
//   in_data_i/valid/ready   : tile input handshake (ready only in IDLE)
//   data_bit_o, mac_en_o    : bit-plane and evaluate strobe to the array
//   adc_i                   : signed ADC codes, adcLatency cycles after mac_en_o
//   out_data_o/valid/ready  : final sums, held until accepted
//   busy_o, tile_idx_o      : status
module seq_acc_tiled
    import qracc_pkg::*;
#(
    parameter int maxInputBits    = 8,
    parameter int inputElements   = 128,
    parameter int outputElements  = 32,
    parameter int adcBits         = 4,
    parameter int accumulatorBits = 24,
    parameter int maxTiles        = 16,
    parameter int adcLatency      = 1
) (
    input  logic                                      clk,
    input  logic                                      nrst,
    input  seq_acc_cfg_t                              cfg,
    input  logic [inputElements*maxInputBits-1:0]     in_data_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    output logic [inputElements-1:0]                  data_bit_o,
    output logic                                      mac_en_o,
    input  logic [outputElements*adcBits-1:0]         adc_i,
    output logic [outputElements*accumulatorBits-1:0] out_data_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic                                      busy_o,
    output logic [(maxTiles > 1 ? $clog2(maxTiles) : 1)-1:0] tile_idx_o
);

    localparam int TileW  = (maxTiles > 1) ? $clog2(maxTiles) : 1;
    localparam int BitW   = 4;
    localparam int DrainW = $clog2(SEQ_ACC_MAX_ADC_LATENCY);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_SERIAL = 2'(ST_SERIAL);
    localparam logic [1:0] S_DRAIN  = 2'(ST_DRAIN);
    localparam logic [1:0] S_OUT    = 2'(ST_OUT);

    logic [1:0]        state_q, state_d;
    logic [TileW-1:0]  tile_idx_q, tile_idx_d;
    logic [TileW-1:0]  t_last_q, t_last_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic [BitW-1:0]   n_eff_q, n_eff_d;
    logic              unsigned_q, unsigned_d;
    logic [3:0]        shifts_q, shifts_d;

    logic [adcLatency-1:0] mac_pipe_q, mac_pipe_d;
    logic [BitW-1:0]       bidx_pipe_q [adcLatency];
    logic [BitW-1:0]       bidx_pipe_d [adcLatency];

    logic [accumulatorBits-1:0] psum_q [outputElements];
    logic [accumulatorBits-1:0] psum_d [outputElements];
    logic [accumulatorBits-1:0] term   [outputElements];

    logic [BitW-1:0]    n_clamp;
    logic [TileW-1:0]   t_last_clamp;
    logic               load_piso;
    logic               clear_psum;
    logic               mac_en;
    logic [inputElements-1:0] piso_bits;
    logic               sample_vld;
    logic [BitW-1:0]    sample_bit;
    logic               sample_neg;

    bit_plane_piso #(
        .lanes (inputElements),
        .depth (maxInputBits)
    ) u_piso (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (load_piso),
        .shift_i (mac_en),
        .data_i  (in_data_i),
        .bits_o  (piso_bits)
    );

    // Zero means one; anything beyond the hardware limit saturates to it.
    always_comb begin
        n_clamp = cfg.n_input_bits;
        if (cfg.n_input_bits == '0) begin
            n_clamp = BitW'(1);
        end else if (int'(cfg.n_input_bits) > maxInputBits) begin
            n_clamp = BitW'(maxInputBits);
        end
        t_last_clamp = TileW'(int'(cfg.n_tiles) - 1);
        if (cfg.n_tiles == '0) begin
            t_last_clamp = '0;
        end else if (int'(cfg.n_tiles) > maxTiles) begin
            t_last_clamp = TileW'(maxTiles - 1);
        end
    end

    // Configuration is only captured when tile 0 is accepted, so later tiles
    // of the same job always see the job's original settings.
    always_comb begin
        state_d     = state_q;
        tile_idx_d  = tile_idx_q;
        t_last_d    = t_last_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        n_eff_d     = n_eff_q;
        unsigned_d  = unsigned_q;
        shifts_d    = shifts_q;
        load_piso   = 1'b0;
        clear_psum  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    load_piso = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_SERIAL;
                    if (tile_idx_q == '0) begin
                        clear_psum = 1'b1;
                        n_eff_d    = n_clamp;
                        unsigned_d = cfg.unsigned_acts;
                        shifts_d   = cfg.adc_ref_range_shifts;
                        t_last_d   = t_last_clamp;
                    end
                end
            end
            S_SERIAL: begin
                if (bit_cnt_q == n_eff_q - BitW'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DrainW'(adcLatency - 1)) begin
                    if (tile_idx_q == t_last_q) begin
                        state_d = S_OUT;
                    end else begin
                        tile_idx_d = tile_idx_q + TileW'(1);
                        state_d    = S_IDLE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    tile_idx_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mac_en = (state_q == S_SERIAL);

    // The strobe and its bit index travel down a delay line matching the ADC
    // latency; accumulation is keyed off the line's tail, not the FSM state.
    always_comb begin
        mac_pipe_d     = '0;
        bidx_pipe_d    = bidx_pipe_q;
        mac_pipe_d[0]  = mac_en;
        bidx_pipe_d[0] = bit_cnt_q;
        for (int i = 1; i < adcLatency; i++) begin
            mac_pipe_d[i]  = mac_pipe_q[i-1];
            bidx_pipe_d[i] = bidx_pipe_q[i-1];
        end
    end

    assign sample_vld = mac_pipe_q[adcLatency-1];
    assign sample_bit = bidx_pipe_q[adcLatency-1];
    // In signed mode the MSB plane carries negative weight.
    assign sample_neg = !unsigned_q && (sample_bit == n_eff_q - BitW'(1));

    always_comb begin
        for (int c = 0; c < outputElements; c++) begin
            term[c] = {{(accumulatorBits-adcBits){adc_i[c*adcBits+adcBits-1]}},
                       adc_i[c*adcBits +: adcBits]} << sample_bit;
        end
    end

    always_comb begin
        psum_d = psum_q;
        for (int c = 0; c < outputElements; c++) begin
            if (clear_psum) begin
                psum_d[c] = '0;
            end else if (sample_vld) begin
                psum_d[c] = sample_neg ? psum_q[c] - term[c] : psum_q[c] + term[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            tile_idx_q  <= '0;
            t_last_q    <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            n_eff_q     <= BitW'(1);
            unsigned_q  <= 1'b0;
            shifts_q    <= '0;
            mac_pipe_q  <= '0;
            for (int i = 0; i < adcLatency; i++) begin
                bidx_pipe_q[i] <= '0;
            end
            for (int c = 0; c < outputElements; c++) begin
                psum_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tile_idx_q  <= tile_idx_d;
            t_last_q    <= t_last_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            n_eff_q     <= n_eff_d;
            unsigned_q  <= unsigned_d;
            shifts_q    <= shifts_d;
            mac_pipe_q  <= mac_pipe_d;
            bidx_pipe_q <= bidx_pipe_d;
            psum_q      <= psum_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign mac_en_o    = mac_en;
    assign data_bit_o  = mac_en ? piso_bits : '0;
    assign out_valid_o = (state_q == S_OUT);
    assign tile_idx_o  = tile_idx_q;

    always_comb begin
        out_data_o = '0;
        for (int c = 0; c < outputElements; c++) begin
            if (out_valid_o) begin
                out_data_o[c*accumulatorBits +: accumulatorBits] = psum_q[c] << shifts_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_acc_tiled.sv
// tb_seq_acc_tiled: self-checking bench for seq_acc_tiled. The ADC model
// returns the popcount of the presented bit-plane one cycle later on every
// column; expected results come from interpreting the lane values as
// integers and summing them over lanes and tiles.
module tb_seq_acc_tiled;
    import qracc_pkg::*;

    localparam int MIB = 8;
    localparam int IE  = 4;
    localparam int OE  = 2;
    localparam int AB  = 4;
    localparam int ACC = 24;
    localparam int MT  = 16;
    localparam int LAT = 1;

    logic                clk = 1'b0;
    logic                nrst;
    seq_acc_cfg_t        cfg;
    logic [IE*MIB-1:0]   in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [IE-1:0]       data_bit_o;
    logic                mac_en_o;
    logic [OE*AB-1:0]    adc_i;
    logic [OE*ACC-1:0]   out_data_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                busy_o;
    logic [3:0]          tile_idx_o;

    int assertCount = 0;
    int failCount   = 0;

    logic [MIB-1:0] tileLanes [MT][IE];
    logic [AB-1:0]  adcCode;

    seq_acc_tiled #(
        .maxInputBits    (MIB),
        .inputElements   (IE),
        .outputElements  (OE),
        .adcBits         (AB),
        .accumulatorBits (ACC),
        .maxTiles        (MT),
        .adcLatency      (LAT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cfg         (cfg),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_bit_o  (data_bit_o),
        .mac_en_o    (mac_en_o),
        .adc_i       (adc_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .tile_idx_o  (tile_idx_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) adcCode <= AB'($countones(data_bit_o));
    assign adc_i = {adcCode, adcCode};

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic longint laneValue(input logic [MIB-1:0] raw, input int n, input bit uns);
        longint v;
        v = longint'(raw) & ((longint'(1) << n) - 1);
        if (!uns && raw[n-1]) v = v - (longint'(1) << n);
        return v;
    endfunction

    task automatic setAllLanes(input int k, input logic [MIB-1:0] val);
        for (int l = 0; l < IE; l++) tileLanes[k][l] = val;
    endtask

    // Runs one complete job from an IDLE cycle. stall holds out_ready_i low for
    // that many extra OUT cycles; pend leaves a new tile waiting during the stall.
    task automatic applyStimulus(input int n, input bit uns, input int t, input int sh,
                                 input int stall, input bit pend);
        int nEff;
        int tEff;
        longint psum;
        logic [ACC-1:0] expOut;
        logic [IE-1:0]  expBits;
        nEff = (n == 0) ? 1 : ((n > MIB) ? MIB : n);
        tEff = (t == 0) ? 1 : ((t > MT) ? MT : t);
        psum = 0;
        for (int k = 0; k < tEff; k++)
            for (int l = 0; l < IE; l++)
                psum += laneValue(tileLanes[k][l], nEff, uns);
        expOut = ACC'(psum << sh);

        cfg.n_input_bits         = 4'(n);
        cfg.unsigned_acts        = uns;
        cfg.n_tiles              = 5'(t);
        cfg.adc_ref_range_shifts = 4'(sh);
        out_ready_i = (stall == 0);

        for (int k = 0; k < tEff; k++) begin
            for (int l = 0; l < IE; l++) begin
                in_data_i[l*MIB +: MIB] = tileLanes[k][l];
                expBits[l] = tileLanes[k][l][0];
            end
            in_valid_i = 1'b1;
            checkOutput("in_ready_tile", 64'(in_ready_o), 64'd1);
            checkOutput("tile_idx", 64'(tile_idx_o), 64'(k));
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            // Configuration changes after the first tile must be ignored.
            cfg.n_input_bits         = 4'($urandom);
            cfg.unsigned_acts        = 1'($urandom);
            cfg.n_tiles              = 5'($urandom);
            cfg.adc_ref_range_shifts = 4'($urandom);
            checkOutput("mac_en_bit0", 64'(mac_en_o), 64'd1);
            checkOutput("data_bit0", 64'(data_bit_o), 64'(expBits));
            checkOutput("in_ready_busy", 64'(in_ready_o), 64'd0);
            repeat (nEff + LAT) @(posedge clk);
            #1;
            if (k < tEff - 1) begin
                checkOutput("in_ready_between", 64'(in_ready_o), 64'd1);
                checkOutput("out_valid_early", 64'(out_valid_o), 64'd0);
            end
        end

        checkOutput("out_valid", 64'(out_valid_o), 64'd1);
        for (int c = 0; c < OE; c++)
            checkOutput("out_data", 64'(out_data_o[c*ACC +: ACC]), 64'(expOut));

        if (stall > 0) begin
            if (pend) begin
                in_valid_i = 1'b1;
                in_data_i  = $urandom;
            end
            repeat (stall) begin
                @(posedge clk); #1;
                checkOutput("stall_valid", 64'(out_valid_o), 64'd1);
                checkOutput("stall_ready", 64'(in_ready_o), 64'd0);
                checkOutput("stall_data", 64'(out_data_o[ACC-1:0]), 64'(expOut));
            end
            out_ready_i = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("done_valid", 64'(out_valid_o), 64'd0);
        checkOutput("done_ready", 64'(in_ready_o), 64'd1);
        checkOutput("done_tile_idx", 64'(tile_idx_o), 64'd0);
    endtask

    initial begin
        nrst        = 1'b0;
        cfg         = '0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready_o), 64'd1);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("rst_out_data", 64'(out_data_o), 64'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Signed positive: lanes 3, N=4 -> 12; out_valid at cycle 6 is covered by the fixed wait.
        setAllLanes(0, 8'h03);
        applyStimulus(4, 1'b0, 1, 0, 0, 1'b0);
        // Signed negative: lanes -1 -> -4.
        setAllLanes(0, 8'h0F);
        applyStimulus(4, 1'b0, 1, 0, 0, 1'b0);
        // Unsigned with range shift: 60 << 2 = 240.
        setAllLanes(0, 8'h0F);
        applyStimulus(4, 1'b1, 1, 2, 0, 1'b0);
        // Three tiles: 4 + 8 - 4 = 8.
        setAllLanes(0, 8'h01);
        setAllLanes(1, 8'h02);
        setAllLanes(2, 8'h0F);
        applyStimulus(4, 1'b0, 3, 0, 0, 1'b0);
        // Back-pressure with a pending tile, then that tile's job is accepted.
        setAllLanes(0, 8'h05);
        applyStimulus(4, 1'b1, 1, 1, 5, 1'b1);
        setAllLanes(0, 8'h06);
        applyStimulus(3, 1'b0, 1, 0, 0, 1'b0);
        // Precision boundaries: signed N=1 weighs -1, N=0 -> 1, N=12 -> 8.
        setAllLanes(0, 8'h01);
        applyStimulus(1, 1'b0, 1, 0, 0, 1'b0);
        setAllLanes(0, 8'h03);
        applyStimulus(0, 1'b1, 1, 0, 0, 1'b0);
        setAllLanes(0, 8'hFF);
        applyStimulus(12, 1'b1, 1, 0, 0, 1'b0);
        // Tile count 0 behaves as one tile.
        setAllLanes(0, 8'h07);
        applyStimulus(4, 1'b1, 0, 0, 0, 1'b0);

        // Reset during bit 2 of a job.
        setAllLanes(0, 8'h03);
        cfg.n_input_bits = 4'd4;
        cfg.unsigned_acts = 1'b0;
        cfg.n_tiles = 5'd1;
        cfg.adc_ref_range_shifts = 4'd0;
        in_data_i = {4{8'h03}};
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_mac_en", 64'(mac_en_o), 64'd1);
        nrst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_in_ready", 64'(in_ready_o), 64'd1);
        checkOutput("midrst_mac_en", 64'(mac_en_o), 64'd0);
        checkOutput("midrst_data_bit", 64'(data_bit_o), 64'd0);
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_tile_idx", 64'(tile_idx_o), 64'd0);
        nrst = 1'b1;
        setAllLanes(0, 8'h02);
        applyStimulus(4, 1'b0, 1, 0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            for (int k = 0; k < 3; k++)
                for (int l = 0; l < IE; l++)
                    tileLanes[k][l] = MIB'($urandom);
            applyStimulus(int'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
